// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit memory controller.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/lsu_store_align.sv
// Store alignment: byte enables, lane-replicated data and misalignment detection.
module lsu_store_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        is_store,
    input  logic [31:0] wdata,
    output logic [3:0]  mask,
    output logic [31:0] wdata_lanes,
    output logic        misaligned
);

    // Misalignment check for all accesses; mask/data only shaped for stores.
    always_comb begin
        mask        = MASK_W;
        wdata_lanes = '0;
        misaligned  = 1'b0;
        case (funct3)
            F3_H, F3_HU: misaligned = addr_lo[0];
            F3_W:        misaligned = |addr_lo;
            default:     misaligned = 1'b0;
        endcase
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    mask        = MASK_B << addr_lo;
                    wdata_lanes = {4{wdata[7:0]}};
                end
                2'b01: begin
                    mask        = MASK_H << addr_lo;
                    wdata_lanes = {2{wdata[15:0]}};
                end
                default: begin
                    mask        = MASK_W;
                    wdata_lanes = wdata;
                end
            endcase
        end
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the MEM stage and a variable-latency data memory.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_valid,
    input  logic        i_mem_ren,
    input  logic        i_mem_wen,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_rdata_valid,
    output logic [31:0] o_rdata,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic        o_dmem_req,
    input  logic        i_dmem_gnt,
    output logic [31:0] o_dmem_addr,
    output logic        o_dmem_wen,
    output logic [3:0]  o_dmem_mask,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata
);

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  f3_q;
    logic        wen_q;
    logic [3:0]  mask_q;
    logic [31:0] tmo_cnt;
    logic        err_q;

    logic        access, accept, tmo_fire, timeout;
    logic [3:0]  al_mask;
    logic [31:0] al_wdata;
    logic        al_mis;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign access  = i_mem_valid & (i_mem_ren | i_mem_wen);
    assign timeout = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TIMEOUT_CYCLES - 1);

    lsu_store_align u_align (
        .funct3      (i_funct3),
        .addr_lo     (i_addr[1:0]),
        .is_store    (i_mem_wen),
        .wdata       (i_wdata),
        .mask        (al_mask),
        .wdata_lanes (al_wdata),
        .misaligned  (al_mis)
    );

    // Next-state and control outputs.
    always_comb begin
        state_nxt    = state;
        o_stall      = 1'b0;
        o_dmem_req   = 1'b0;
        o_misaligned = 1'b0;
        accept       = 1'b0;
        tmo_fire     = 1'b0;
        case (state)
            S_IDLE: begin
                if (access) begin
                    if (al_mis) begin
                        o_misaligned = 1'b1;
                    end else begin
                        o_stall   = 1'b1;
                        accept    = 1'b1;
                        state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                o_stall    = 1'b1;
                o_dmem_req = 1'b1;
                if (i_dmem_gnt) begin
                    state_nxt = wen_q ? S_DONE : S_WAIT;
                end else if (timeout) begin
                    tmo_fire  = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_WAIT: begin
                o_stall = 1'b1;
                if (i_dmem_rvalid) begin
                    state_nxt = S_DONE;
                end else if (timeout) begin
                    tmo_fire  = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign o_rdata_valid = (state == S_DONE) & ~wen_q;
    assign o_bus_err     = (state == S_DONE) & err_q;
    assign o_dmem_addr   = {addr_q[31:2], 2'b00};
    assign o_dmem_wen    = wen_q;
    assign o_dmem_mask   = mask_q;
    assign o_dmem_wdata  = wdata_q;

    // Load data extension by latched funct3 and byte offset.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = i_dmem_rdata[7:0];
            2'd1:    ld_byte = i_dmem_rdata[15:8];
            2'd2:    ld_byte = i_dmem_rdata[23:16];
            default: ld_byte = i_dmem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        case (f3_q)
            F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_ext = {24'd0, ld_byte};
            F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_ext = {16'd0, ld_half};
            default: ld_ext = i_dmem_rdata;
        endcase
    end

    // State register, field latches, timeout counter and load data register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            wen_q   <= 1'b0;
            mask_q  <= '0;
            tmo_cnt <= '0;
            err_q   <= 1'b0;
            o_rdata <= '0;
        end else begin
            state <= state_nxt;
            err_q <= tmo_fire;
            if (accept) begin
                addr_q  <= i_addr;
                f3_q    <= i_funct3;
                wen_q   <= i_mem_wen;
                mask_q  <= al_mask;
                wdata_q <= al_wdata;
            end
            // Counter restarts on each entry into REQ or WAIT, so WAIT gets its own full budget.
            if ((state_nxt != state) && (state_nxt == S_REQ || state_nxt == S_WAIT)) begin
                tmo_cnt <= '0;
            end else if (state == S_REQ || state == S_WAIT) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end
            if (state == S_WAIT && i_dmem_rvalid) begin
                o_rdata <= ld_ext;
            end else if (tmo_fire) begin
                o_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl.
module tb_lsu_mem_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_mem_valid, i_mem_ren, i_mem_wen;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_wdata;
    logic        o_stall, o_rdata_valid, o_misaligned, o_bus_err;
    logic [31:0] o_rdata;
    logic        o_dmem_req, i_dmem_gnt, o_dmem_wen;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic [3:0]  o_dmem_mask;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;

    int compared = 0;
    int mismatched = 0;
    int stall_seen = 0;

    always #5 i_clk = ~i_clk;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_mem_valid   (i_mem_valid),
        .i_mem_ren     (i_mem_ren),
        .i_mem_wen     (i_mem_wen),
        .i_funct3      (i_funct3),
        .i_addr        (i_addr),
        .i_wdata       (i_wdata),
        .o_stall       (o_stall),
        .o_rdata_valid (o_rdata_valid),
        .o_rdata       (o_rdata),
        .o_misaligned  (o_misaligned),
        .o_bus_err     (o_bus_err),
        .o_dmem_req    (o_dmem_req),
        .i_dmem_gnt    (i_dmem_gnt),
        .o_dmem_addr   (o_dmem_addr),
        .o_dmem_wen    (o_dmem_wen),
        .o_dmem_mask   (o_dmem_mask),
        .o_dmem_wdata  (o_dmem_wdata),
        .i_dmem_rvalid (i_dmem_rvalid),
        .i_dmem_rdata  (i_dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge i_clk);
        if (o_stall === 1'b1) stall_seen++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, {31'd0, o_stall}, 32'd0);
        chk({tag, "_req"}, {31'd0, o_dmem_req}, 32'd0);
        chk({tag, "_rvalid"}, {31'd0, o_rdata_valid}, 32'd0);
        chk({tag, "_rdata"}, o_rdata, 32'd0);
        chk({tag, "_berr"}, {31'd0, o_bus_err}, 32'd0);
        chk({tag, "_mis"}, {31'd0, o_misaligned}, 32'd0);
        chk({tag, "_daddr"}, o_dmem_addr, 32'd0);
        chk({tag, "_dmask"}, {28'd0, o_dmem_mask}, 32'd0);
        chk({tag, "_dwdata"}, o_dmem_wdata, 32'd0);
        chk({tag, "_dwen"}, {31'd0, o_dmem_wen}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst = 1'b1; i_mem_valid = 1'b0; i_mem_ren = 1'b0; i_mem_wen = 1'b0;
        i_funct3 = 3'b000; i_addr = '0; i_wdata = '0;
        i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
        step(); step();
        smp();
        chk_all_zero("reset");
        step();
        i_rst = 1'b0;
        step();

        // SB addr 0x103 data 0xAB, gnt in first REQ cycle
        stall_seen = 0;
        i_mem_valid = 1; i_mem_wen = 1; i_funct3 = 3'b000; i_addr = 32'h103; i_wdata = 32'hAB;
        smp();
        chk("sb_idle_stall", {31'd0, o_stall}, 32'd1);
        chk("sb_idle_req", {31'd0, o_dmem_req}, 32'd0);
        step();
        i_mem_valid = 0; i_mem_wen = 0; i_addr = 32'hDEAD_BEEF; i_wdata = 32'h1234_5678; i_dmem_gnt = 1;
        smp();
        chk("sb_req", {31'd0, o_dmem_req}, 32'd1);
        chk("sb_addr", o_dmem_addr, 32'h100);
        chk("sb_mask", {28'd0, o_dmem_mask}, 32'h8);
        chk("sb_wdata", o_dmem_wdata, 32'hABAB_ABAB);
        chk("sb_wen", {31'd0, o_dmem_wen}, 32'd1);
        step();
        i_dmem_gnt = 0;
        smp();
        chk("sb_done_stall", {31'd0, o_stall}, 32'd0);
        chk("sb_done_rvalid", {31'd0, o_rdata_valid}, 32'd0);
        chk("sb_done_req", {31'd0, o_dmem_req}, 32'd0);
        chk("sb_stall_cycles", stall_seen, 32'd2);
        step();

        // SH addr 0x12 data 0x12345678
        i_mem_valid = 1; i_mem_wen = 1; i_funct3 = 3'b001; i_addr = 32'h12; i_wdata = 32'h1234_5678;
        smp();
        step();
        i_mem_valid = 0; i_mem_wen = 0; i_dmem_gnt = 1;
        smp();
        chk("sh_addr", o_dmem_addr, 32'h10);
        chk("sh_mask", {28'd0, o_dmem_mask}, 32'hC);
        chk("sh_wdata", o_dmem_wdata, 32'h5678_5678);
        step();
        i_dmem_gnt = 0;
        smp();
        step();

        // LB addr 0x2, rdata 0x0080_0000, rvalid one cycle after gnt
        stall_seen = 0;
        i_mem_valid = 1; i_mem_ren = 1; i_funct3 = 3'b000; i_addr = 32'h2;
        smp();
        chk("lb_idle_stall", {31'd0, o_stall}, 32'd1);
        step();
        i_mem_valid = 0; i_mem_ren = 0; i_dmem_gnt = 1;
        smp();
        chk("lb_req", {31'd0, o_dmem_req}, 32'd1);
        chk("lb_mask", {28'd0, o_dmem_mask}, 32'hF);
        chk("lb_wdata", o_dmem_wdata, 32'd0);
        chk("lb_wen", {31'd0, o_dmem_wen}, 32'd0);
        chk("lb_addr", o_dmem_addr, 32'h0);
        step();
        i_dmem_gnt = 0; i_dmem_rvalid = 1; i_dmem_rdata = 32'h0080_0000;
        smp();
        chk("lb_wait_stall", {31'd0, o_stall}, 32'd1);
        chk("lb_wait_req", {31'd0, o_dmem_req}, 32'd0);
        step();
        i_dmem_rvalid = 0; i_dmem_rdata = 32'h5555_5555;
        smp();
        chk("lb_done_stall", {31'd0, o_stall}, 32'd0);
        chk("lb_done_rvalid", {31'd0, o_rdata_valid}, 32'd1);
        chk("lb_rdata", o_rdata, 32'hFFFF_FF80);
        chk("lb_berr", {31'd0, o_bus_err}, 32'd0);
        chk("lb_stall_cycles", stall_seen, 32'd3);
        step();
        smp();
        chk("lb_after_rvalid", {31'd0, o_rdata_valid}, 32'd0);
        chk("lb_rdata_hold", o_rdata, 32'hFFFF_FF80);

        // LHU addr 0x2, rdata 0x8001_1234, gnt delayed 4 cycles
        stall_seen = 0;
        step();
        i_mem_valid = 1; i_mem_ren = 1; i_funct3 = 3'b101; i_addr = 32'h2;
        smp();
        step();
        i_mem_valid = 0; i_mem_ren = 0;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("lhu_req_wait", {31'd0, o_dmem_req}, 32'd1);
            step();
        end
        i_dmem_gnt = 1;
        smp();
        step();
        i_dmem_gnt = 0; i_dmem_rvalid = 1; i_dmem_rdata = 32'h8001_1234;
        smp();
        step();
        i_dmem_rvalid = 0;
        smp();
        chk("lhu_rvalid", {31'd0, o_rdata_valid}, 32'd1);
        chk("lhu_rdata", o_rdata, 32'h0000_8001);
        chk("lhu_stall_cycles", stall_seen, 32'd7);
        step();

        // LW addr 0x6: misaligned, no stall, no request
        i_mem_valid = 1; i_mem_ren = 1; i_funct3 = 3'b010; i_addr = 32'h6;
        smp();
        chk("lw_mis", {31'd0, o_misaligned}, 32'd1);
        chk("lw_mis_stall", {31'd0, o_stall}, 32'd0);
        chk("lw_mis_req", {31'd0, o_dmem_req}, 32'd0);
        step();
        smp();
        chk("lw_mis_req2", {31'd0, o_dmem_req}, 32'd0);
        step();
        i_mem_valid = 0; i_mem_ren = 0;
        smp();
        chk("lw_mis_clear", {31'd0, o_misaligned}, 32'd0);
        step();

        // Reset during WAIT, stale rvalid afterwards
        i_mem_valid = 1; i_mem_ren = 1; i_funct3 = 3'b010; i_addr = 32'h20;
        smp();
        step();
        i_mem_valid = 0; i_mem_ren = 0; i_dmem_gnt = 1;
        smp();
        step();
        i_dmem_gnt = 0;
        smp();
        chk("rst_wait_stall", {31'd0, o_stall}, 32'd1);
        step();
        i_rst = 1;
        smp();
        chk_all_zero("rst_mid");
        step();
        i_rst = 0;
        step();
        i_dmem_rvalid = 1; i_dmem_rdata = 32'hFFFF_FFFF;
        smp();
        chk("stale_stall", {31'd0, o_stall}, 32'd0);
        chk("stale_req", {31'd0, o_dmem_req}, 32'd0);
        step();
        i_dmem_rvalid = 0;
        smp();
        chk("stale_rvalid", {31'd0, o_rdata_valid}, 32'd0);
        chk("stale_rdata", o_rdata, 32'd0);
        step();

        // LW addr 0x44, gnt never: bus error after 8 REQ cycles
        i_mem_valid = 1; i_mem_ren = 1; i_funct3 = 3'b010; i_addr = 32'h44;
        smp();
        step();
        i_mem_valid = 0; i_mem_ren = 0;
        for (int k = 0; k < 8; k++) begin
            smp();
            chk("tmo_req", {31'd0, o_dmem_req}, 32'd1);
            chk("tmo_no_err", {31'd0, o_bus_err}, 32'd0);
            step();
        end
        smp();
        chk("tmo_berr", {31'd0, o_bus_err}, 32'd1);
        chk("tmo_rvalid", {31'd0, o_rdata_valid}, 32'd1);
        chk("tmo_rdata", o_rdata, 32'd0);
        chk("tmo_stall", {31'd0, o_stall}, 32'd0);
        step();
        smp();
        chk("tmo_idle_berr", {31'd0, o_bus_err}, 32'd0);
        chk("tmo_idle_req", {31'd0, o_dmem_req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
